// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
//   Posted-write buffer between the core data port and the data SRAM.
//   Stores are queued in a small circular FIFO and written to the SRAM on
//   cycles where the core leaves memory alone. Loads see buffered data first.
//   A store to an address that is already queued overwrites that entry, so
//   each address appears at most once. The core is stalled only when a new
//   address arrives while the buffer is full; that stall cycle drains the head.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 7,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       core_cen,
  input  logic                       core_wen,
  input  logic [AW-1:0]              core_a,
  input  logic [DW-1:0]              core_d,
  output logic [DW-1:0]              core_q,
  output logic                       stall_o,
  output logic                       mem_cen,
  output logic                       mem_wen,
  output logic [AW-1:0]              mem_a,
  output logic [DW-1:0]              mem_d,
  output logic                       mem_oen,
  input  logic [DW-1:0]              mem_q,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  // Kind of core access presented this cycle.
  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_LOAD,
    ACC_STORE
  } acc_e;

  // Entry storage: valid bits are reset, payload is not.
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  ptr_t             head;
  ptr_t             tail;
  cnt_t             count;

  acc_e acc;
  logic hit;
  ptr_t hit_idx;
  logic full;
  logic push;
  logic coalesce;
  logic drain;
  logic stall;

  // Classify the core request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and no latch is inferred.
    acc = ACC_IDLE;
    if (!core_cen) acc = core_wen ? ACC_LOAD : ACC_STORE;
  end

  // Associative lookup of core_a among the valid entries (addresses are unique).
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == core_a)) begin
        hit     = 1'b1;
        hit_idx = ptr_t'(i);
      end
    end
  end

  // Per-cycle decision: coalesce, push, or drain (push and drain never coincide).
  always_comb begin
    full     = (count == cnt_t'(DEPTH));
    coalesce = (acc == ACC_STORE) && hit;
    push     = (acc == ACC_STORE) && !hit && !full;
    stall    = (acc == ACC_STORE) && !hit && full;
    drain    = stall || ((acc == ACC_IDLE) && (count != '0));
  end

  // Port outputs; reset forces the SRAM idle and the core unstalled.
  always_comb begin
    stall_o = rst_n && stall;
    mem_cen = !(rst_n && ((acc == ACC_LOAD) || drain));
    mem_wen = !(rst_n && drain);
    mem_a   = drain ? addr_q[head] : core_a;
    mem_d   = data_q[head];
    mem_oen = 1'b0;
    count_o = count;
    empty_o = (count == '0);
    if (!rst_n)                         core_q = '0;
    else if ((acc == ACC_LOAD) && hit)  core_q = data_q[hit_idx];
    else                                core_q = mem_q;
  end

  // Queue bookkeeping: pointers, occupancy and valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
      if (push) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + ptr_t'(1);
        count         <= count + cnt_t'(1);
      end
      if (drain) begin
        valid_q[head] <= 1'b0;
        head          <= head + ptr_t'(1);
        count         <= count - cnt_t'(1);
      end
    end
  end

  // Entry payload: written on push, data overwritten on coalesce.
  always_ff @(posedge clk) begin
    // NOTE: payload arrays are not reset; valid_q alone decides whether an entry is meaningful, which keeps the storage plain RAM-style flops.
    if (push) begin
      addr_q[tail] <= core_a;
      data_q[tail] <= core_d;
    end else if (coalesce) begin
      data_q[hit_idx] <= core_d;
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer
//   Directed scenarios plus a randomized run against a queue-based reference
//   model of the store buffer and a behavioural SRAM that samples on negedge.
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 7;
  localparam int DW    = 32;

  logic          clk = 1'b1;
  logic          rst_n;
  logic          core_cen, core_wen;
  logic [AW-1:0] core_a;
  logic [DW-1:0] core_d;
  logic [DW-1:0] core_q;
  logic          stall_o, mem_cen, mem_wen, mem_oen, empty_o;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q = '0;
  logic [2:0]    count_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_cen(core_cen), .core_wen(core_wen), .core_a(core_a), .core_d(core_d),
    .core_q(core_q), .stall_o(stall_o),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d),
    .mem_oen(mem_oen), .mem_q(mem_q),
    .count_o(count_o), .empty_o(empty_o)
  );

  // Behavioural SRAM, sampled at mid-cycle.
  logic [DW-1:0] sram   [0:127];
  int            wr_cnt [0:127];
  always @(negedge clk) begin
    if (!mem_cen) begin
      if (!mem_wen) begin
        sram[mem_a]   <= mem_d;
        wr_cnt[mem_a] <= wr_cnt[mem_a] + 1;
      end else begin
        mem_q <= sram[mem_a];
      end
    end
  end

  // Reference model: FIFO of unique addresses plus the expected SRAM image.
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t          mq[$];
  logic [DW-1:0] ref_mem [0:127];
  logic [DW-1:0] ref_q = '0;

  // Expected and observed values of one cycle.
  logic          e_stall, e_cen, e_wen, e_empty, o_stall, o_cen, o_wen, o_empty;
  logic [AW-1:0] e_a, o_a;
  logic [DW-1:0] e_d, o_d, e_q, o_q;
  logic [2:0]    e_cnt, o_cnt;

  // Drive one core cycle (entered at posedge+1), advance the model, capture outputs.
  task automatic step(input logic cen, input logic wen, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int   idx;
    logic do_drain;
    ent_t ent;
    core_cen = cen; core_wen = wen; core_a = addr; core_d = data;
    idx = -1;
    foreach (mq[i]) if (mq[i].a == addr) idx = i;
    e_stall = 1'b0; e_cen = 1'b1; e_wen = 1'b1; e_a = '0; e_d = '0;
    e_cnt = 3'(mq.size()); e_empty = (mq.size() == 0); e_q = ref_q; do_drain = 1'b0;
    if (!cen && wen) begin
      e_cen = 1'b0; e_a = addr;
      ref_q = ref_mem[addr];
      e_q   = (idx >= 0) ? mq[idx].d : ref_mem[addr];
    end else if (!cen) begin
      if (idx >= 0) begin
        ent = mq[idx]; ent.d = data; mq[idx] = ent;
      end else if (mq.size() < DEPTH) begin
        ent.a = addr; ent.d = data; mq.push_back(ent);
      end else begin
        e_stall = 1'b1; do_drain = 1'b1;
      end
    end else if (mq.size() > 0) begin
      do_drain = 1'b1;
    end
    if (do_drain) begin
      ent = mq.pop_front();
      e_cen = 1'b0; e_wen = 1'b0; e_a = ent.a; e_d = ent.d;
      ref_mem[ent.a] = ent.d;
    end
    #2;
    o_stall = stall_o; o_cen = mem_cen; o_wen = mem_wen; o_cnt = count_o; o_empty = empty_o;
    o_a = mem_cen ? '0 : mem_a;
    o_d = (!mem_cen && !mem_wen) ? mem_d : '0;
    @(negedge clk); #1;
    o_q = core_q;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; core_cen = 1'b1; core_wen = 1'b1; core_a = '0; core_d = '0;
    #3;
    n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
    n_checks++; if (mem_cen !== 1'b1 || mem_wen !== 1'b1) begin n_fail++; $display("FAIL reset_mem_ctl got cen=%b wen=%b exp 1/1", mem_cen, mem_wen); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    n_checks++; if (mem_oen !== 1'b0) begin n_fail++; $display("FAIL mem_oen got=%b exp=0", mem_oen); end
    core_cen = 1'b0; core_a = 7'd1;
    #4;
    n_checks++; if (mem_cen !== 1'b1 || core_q !== '0) begin n_fail++; $display("FAIL reset_load_gate got cen=%b q=%0d exp cen=1 q=0", mem_cen, core_q); end
    core_cen = 1'b1;
    #8;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    step(1'b0, 1'b0, 7'd4, 32'd30);
    n_checks++; if (o_stall !== 1'b0 || o_cen !== 1'b1) begin n_fail++; $display("FAIL t2_store got stall=%b cen=%b exp 0/1", o_stall, o_cen); end
    step(1'b0, 1'b1, 7'd4, 32'd0);
    n_checks++; if (o_q !== 32'd30) begin n_fail++; $display("FAIL t2_fwd_q got=%0d exp=30", o_q); end
    n_checks++; if (o_cen !== 1'b0 || o_wen !== 1'b1) begin n_fail++; $display("FAIL t2_load_ctl got cen=%b wen=%b exp 0/1", o_cen, o_wen); end
    n_checks++; if (wr_cnt[4] !== 0) begin n_fail++; $display("FAIL t2_not_written got writes=%0d exp=0", wr_cnt[4]); end
    step(1'b1, 1'b1, 7'd0, 32'd0);
    n_checks++; if ({o_cen, o_wen, o_a, o_d} !== {1'b0, 1'b0, 7'd4, 32'd30}) begin n_fail++; $display("FAIL t2_drain got cen=%b wen=%b a=%0d d=%0d exp 0/0/4/30", o_cen, o_wen, o_a, o_d); end
    n_checks++; if (o_cnt !== 3'd1 || count_o !== 3'd0) begin n_fail++; $display("FAIL t2_count got %0d->%0d exp 1->0", o_cnt, count_o); end
  endtask

  task automatic test_coalesce();
    int w0;
    w0 = wr_cnt[2];
    step(1'b0, 1'b0, 7'd2, 32'd5);
    step(1'b0, 1'b0, 7'd2, 32'd9);
    n_checks++; if (count_o !== 3'd1) begin n_fail++; $display("FAIL t3_count got=%0d exp=1", count_o); end
    step(1'b1, 1'b1, 7'd0, 32'd0);
    n_checks++; if (o_a !== 7'd2 || o_d !== 32'd9) begin n_fail++; $display("FAIL t3_drain got a=%0d d=%0d exp 2/9", o_a, o_d); end
    step(1'b1, 1'b1, 7'd0, 32'd0);
    n_checks++; if (o_cen !== 1'b1) begin n_fail++; $display("FAIL t3_extra_access got cen=%b exp=1", o_cen); end
    n_checks++; if (wr_cnt[2] - w0 !== 1 || sram[2] !== 32'd9) begin n_fail++; $display("FAIL t3_sram got writes=%0d mem=%0d exp 1/9", wr_cnt[2] - w0, sram[2]); end
  endtask

  task automatic test_full_stall();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 7'(8 + i), 32'(108 + i));
    n_checks++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL t4_full got=%0d exp=4", count_o); end
    step(1'b0, 1'b0, 7'd12, 32'd112);
    n_checks++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL t4_stall got=%b exp=1", o_stall); end
    n_checks++; if ({o_cen, o_wen, o_a, o_d} !== {1'b0, 1'b0, 7'd8, 32'd108}) begin n_fail++; $display("FAIL t4_stall_drain got cen=%b wen=%b a=%0d d=%0d exp 0/0/8/108", o_cen, o_wen, o_a, o_d); end
    step(1'b0, 1'b0, 7'd12, 32'd112);
    n_checks++; if (o_stall !== 1'b0 || count_o !== 3'd4) begin n_fail++; $display("FAIL t4_retry got stall=%b count=%0d exp 0/4", o_stall, count_o); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 7'd0, 32'd0);
      n_checks++; if (o_cen !== 1'b0 || o_a !== 7'(9 + i) || o_d !== 32'(109 + i)) begin n_fail++; $display("FAIL t4_order got cen=%b a=%0d d=%0d exp 0/%0d/%0d", o_cen, o_a, o_d, 9 + i, 109 + i); end
    end
    n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL t4_empty got=%0d exp=0", count_o); end
  endtask

  task automatic test_load_miss();
    step(1'b0, 1'b0, 7'd6, 32'd66);
    step(1'b0, 1'b1, 7'd1, 32'd0);
    n_checks++; if (o_q !== 32'd20) begin n_fail++; $display("FAIL t5_load_q got=%0d exp=20", o_q); end
    n_checks++; if (o_wen !== 1'b1 || o_a !== 7'd1) begin n_fail++; $display("FAIL t5_no_drain got wen=%b a=%0d exp 1/1", o_wen, o_a); end
    n_checks++; if (o_cnt !== 3'd1 || count_o !== 3'd1) begin n_fail++; $display("FAIL t5_count got %0d->%0d exp 1->1", o_cnt, count_o); end
    step(1'b1, 1'b1, 7'd0, 32'd0);
  endtask

  task automatic test_reset_midop();
    int w0;
    step(1'b0, 1'b0, 7'd3, 32'd33);
    step(1'b0, 1'b0, 7'd5, 32'd55);
    step(1'b0, 1'b0, 7'd7, 32'd77);
    n_checks++; if (count_o !== 3'd3) begin n_fail++; $display("FAIL t6_queued got=%0d exp=3", count_o); end
    w0 = wr_cnt[3] + wr_cnt[5] + wr_cnt[7];
    core_cen = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (count_o !== 3'd0 || empty_o !== 1'b1 || mem_cen !== 1'b1) begin n_fail++; $display("FAIL t6_async got count=%0d empty=%b cen=%b exp 0/1/1", count_o, empty_o, mem_cen); end
    mq.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 7'd0, 32'd0);
      n_checks++; if (o_cen !== 1'b1) begin n_fail++; $display("FAIL t6_idle_access got cen=%b exp=1", o_cen); end
    end
    n_checks++; if (wr_cnt[3] + wr_cnt[5] + wr_cnt[7] !== w0) begin n_fail++; $display("FAIL t6_discarded got writes=%0d exp=%0d", wr_cnt[3] + wr_cnt[5] + wr_cnt[7], w0); end
  endtask

  task automatic test_random();
    logic          cen, wen, retry;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            bad;
    retry = 1'b0; cen = 1'b1; wen = 1'b1; a = '0; d = '0;
    for (int n = 0; n < 400; n++) begin
      if (!retry) begin
        cen = ($urandom_range(0, 3) == 0);
        wen = $urandom_range(0, 1) == 1;
        a   = 7'($urandom_range(0, 15));
        d   = $urandom;
      end
      step(cen, wen, a, d);
      retry = e_stall;
      n_checks++;
      if ({o_stall, o_cen, o_wen, o_a, o_d, o_q, o_cnt, o_empty} !== {e_stall, e_cen, e_wen, e_a, e_d, e_q, e_cnt, e_empty}) begin
        n_fail++;
        $display("FAIL rand_cycle%0d got stall=%b cen=%b wen=%b a=%0d d=%h q=%h cnt=%0d empty=%b exp stall=%b cen=%b wen=%b a=%0d d=%h q=%h cnt=%0d empty=%b",
                 n, o_stall, o_cen, o_wen, o_a, o_d, o_q, o_cnt, o_empty, e_stall, e_cen, e_wen, e_a, e_d, e_q, e_cnt, e_empty);
      end
      n_checks++; if (count_o > 3'(DEPTH)) begin n_fail++; $display("FAIL rand_count_bound got=%0d exp<=%0d", count_o, DEPTH); end
    end
    for (int n = 0; n < DEPTH + 2; n++) step(1'b1, 1'b1, 7'd0, 32'd0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (sram[i] !== ref_mem[i]) bad++;
    n_checks++; if (bad !== 0 || count_o !== 3'd0) begin n_fail++; $display("FAIL rand_sram_image got bad_words=%0d count=%0d exp 0/0", bad, count_o); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      sram[i] = '0; ref_mem[i] = '0; wr_cnt[i] = 0;
    end
    sram[0] = 32'd15; ref_mem[0] = 32'd15;
    sram[1] = 32'd20; ref_mem[1] = 32'd20;
    test_reset();
    test_forward();
    test_coalesce();
    test_full_stall();
    test_load_miss();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
